// File: rtl/memory_stage.sv
// Memory pipeline stage: M/W pipeline registers plus a data-memory handshake
// FSM that stalls the front of the pipe until ack or a bounded timeout.
module memory_stage #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteE,
   input  logic        MemWriteE,
   input  logic        jumpE,
   input  logic [3:0]  MemtoRegE,
   input  logic [4:0]  WriteRegE,
   input  logic [31:0] ALUMultOutE,
   input  logic [31:0] WriteDataE,
   input  logic [31:0] PCPlus4E,
   output logic        RegWriteM,
   output logic        jumpM,
   output logic [4:0]  WriteRegM,
   output logic [31:0] ALUOutM,
   output logic [3:0]  MemtoRegM,
   output logic        StallM,
   output logic        MemErr,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        RegWriteW,
   output logic [4:0]  WriteRegW,
   output logic [1:0]  MemtoRegW,
   output logic [31:0] ReadDataW,
   output logic [31:0] ALUOutW,
   output logic [31:0] PCPlus4W
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RETIRE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic        RegWriteM_q, MemWriteM_q, jumpM_q;
   logic [3:0]  MemtoRegM_q;
   logic [4:0]  WriteRegM_q;
   logic [31:0] ALUOutM_q, WriteDataM_q, PCPlus4M_q;

   logic        RegWriteW_q;
   logic [4:0]  WriteRegW_q;
   logic [1:0]  MemtoRegW_q;
   logic [31:0] ReadDataW_q, ALUOutW_q, PCPlus4W_q;
   logic        mem_err_q;

   logic is_store, is_load, req, timeout_now, stall;

   // Classify the M-stage op and derive the handshake / stall terms
   always_comb begin
      is_store    = MemWriteM_q;
      is_load     = (MemtoRegM_q[1:0] == 2'b01) && !MemWriteM_q;
      req         = (is_store || is_load) && (state_q == S_IDLE || state_q == S_WAIT);
      timeout_now = (state_q == S_WAIT) && (cnt_q == CNT_LAST) && !dmem_ack;
      stall       = req && !dmem_ack && !timeout_now;
   end

   // Handshake FSM next state and wait-counter update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req && !dmem_ack) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end
         end
         S_WAIT: begin
            if (dmem_ack) begin
               state_d = S_IDLE;
            end else if (timeout_now) begin
               state_d = S_RETIRE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RETIRE: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // FSM state, wait counter and sticky timeout flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (timeout_now) mem_err_q <= 1'b1;
      end
   end

   // M-stage pipeline registers, frozen while stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         RegWriteM_q  <= 1'b0;
         MemWriteM_q  <= 1'b0;
         jumpM_q      <= 1'b0;
         MemtoRegM_q  <= 4'b1110;
         WriteRegM_q  <= '0;
         ALUOutM_q    <= '0;
         WriteDataM_q <= '0;
         PCPlus4M_q   <= '0;
      end else if (!stall) begin
         RegWriteM_q  <= RegWriteE;
         MemWriteM_q  <= MemWriteE;
         jumpM_q      <= jumpE;
         MemtoRegM_q  <= MemtoRegE;
         WriteRegM_q  <= WriteRegE;
         ALUOutM_q    <= ALUMultOutE;
         WriteDataM_q <= WriteDataE;
         PCPlus4M_q   <= PCPlus4E;
      end
   end

   // W-stage registers; a stalled edge only kills the write enable (bubble)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         RegWriteW_q <= 1'b0;
         WriteRegW_q <= '0;
         MemtoRegW_q <= 2'b10;
         ReadDataW_q <= '0;
         ALUOutW_q   <= '0;
         PCPlus4W_q  <= '0;
      end else if (stall) begin
         RegWriteW_q <= 1'b0;
      end else begin
         RegWriteW_q <= RegWriteM_q && !timeout_now;
         WriteRegW_q <= WriteRegM_q;
         MemtoRegW_q <= MemtoRegM_q[1:0];
         ReadDataW_q <= (is_load && req && dmem_ack) ? dmem_rdata : 32'h0;
         ALUOutW_q   <= ALUOutM_q;
         PCPlus4W_q  <= PCPlus4M_q;
      end
   end

   assign RegWriteM  = RegWriteM_q;
   assign jumpM      = jumpM_q;
   assign WriteRegM  = WriteRegM_q;
   assign ALUOutM    = ALUOutM_q;
   assign MemtoRegM  = MemtoRegM_q;
   assign StallM     = stall;
   assign MemErr     = mem_err_q;
   assign dmem_req   = req;
   assign dmem_we    = MemWriteM_q;
   assign dmem_addr  = ALUOutM_q;
   assign dmem_wdata = WriteDataM_q;
   assign RegWriteW  = RegWriteW_q;
   assign WriteRegW  = WriteRegW_q;
   assign MemtoRegW  = MemtoRegW_q;
   assign ReadDataW  = ReadDataW_q;
   assign ALUOutW    = ALUOutW_q;
   assign PCPlus4W   = PCPlus4W_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: ALU pass-through, load/store handshakes,
// access timeout and reset during an in-flight access.
module tb_memory_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        RegWriteE, MemWriteE, jumpE;
   logic [3:0]  MemtoRegE;
   logic [4:0]  WriteRegE;
   logic [31:0] ALUMultOutE, WriteDataE, PCPlus4E;
   logic        RegWriteM, jumpM;
   logic [4:0]  WriteRegM;
   logic [31:0] ALUOutM;
   logic [3:0]  MemtoRegM;
   logic        StallM, MemErr;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        dmem_ack;
   logic        RegWriteW;
   logic [4:0]  WriteRegW;
   logic [1:0]  MemtoRegW;
   logic [31:0] ReadDataW, ALUOutW, PCPlus4W;

   int n_checks = 0;
   int n_fail   = 0;
   int stalls;

   memory_stage #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .jumpE(jumpE),
      .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE),
      .ALUMultOutE(ALUMultOutE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
      .RegWriteM(RegWriteM), .jumpM(jumpM), .WriteRegM(WriteRegM),
      .ALUOutM(ALUOutM), .MemtoRegM(MemtoRegM),
      .StallM(StallM), .MemErr(MemErr),
      .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .MemtoRegW(MemtoRegW),
      .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .PCPlus4W(PCPlus4W)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Inputs are driven 1 time unit after a rising edge, outputs sampled 1 unit later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive_e(input logic rw, input logic mw, input logic [3:0] m2r,
                          input logic [4:0] wr, input logic [31:0] alu,
                          input logic [31:0] wd, input logic [31:0] pc4);
      RegWriteE   = rw;
      MemWriteE   = mw;
      jumpE       = 1'b0;
      MemtoRegE   = m2r;
      WriteRegE   = wr;
      ALUMultOutE = alu;
      WriteDataE  = wd;
      PCPlus4E    = pc4;
   endtask

   task automatic nop_e();
      drive_e(1'b0, 1'b0, 4'b0010, 5'd0, 32'h0, 32'h0, 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      dmem_ack = 1'b0;
      dmem_rdata = 32'h0;
      nop_e();

      // Reset state
      #12;
      chk("rst_MemtoRegM", 32'(MemtoRegM), 32'hE);
      chk("rst_MemtoRegW", 32'(MemtoRegW), 32'h2);
      chk("rst_StallM",    32'(StallM),    32'h0);
      chk("rst_dmem_req",  32'(dmem_req),  32'h0);
      chk("rst_RegWriteW", 32'(RegWriteW), 32'h0);
      chk("rst_MemErr",    32'(MemErr),    32'h0);
      rst = 1'b0;

      // ALU op flows M then W without touching memory
      tick();
      drive_e(1'b1, 1'b0, 4'b0010, 5'd5, 32'h1234, 32'h0, 32'h104);
      tick();
      nop_e();
      settle();
      chk("alu_ALUOutM",   ALUOutM,            32'h1234);
      chk("alu_RegWriteM", 32'(RegWriteM),     32'h1);
      chk("alu_req_m",     32'(dmem_req),      32'h0);
      tick();
      settle();
      chk("alu_ALUOutW",   ALUOutW,            32'h1234);
      chk("alu_RegWriteW", 32'(RegWriteW),     32'h1);
      chk("alu_WriteRegW", 32'(WriteRegW),     32'h5);
      chk("alu_PCPlus4W",  PCPlus4W,           32'h104);
      chk("alu_req_w",     32'(dmem_req),      32'h0);

      // Load with same-cycle ack: no stall
      tick();
      drive_e(1'b1, 1'b0, 4'b0001, 5'd7, 32'h40, 32'h0, 32'h108);
      tick();
      nop_e();
      dmem_ack = 1'b1;
      dmem_rdata = 32'hDEADBEEF;
      settle();
      chk("ld_req",    32'(dmem_req), 32'h1);
      chk("ld_we",     32'(dmem_we),  32'h0);
      chk("ld_addr",   dmem_addr,     32'h40);
      chk("ld_StallM", 32'(StallM),   32'h0);
      tick();
      dmem_ack = 1'b0;
      dmem_rdata = 32'h0;
      settle();
      chk("ld_ReadDataW", ReadDataW,         32'hDEADBEEF);
      chk("ld_MemtoRegW", 32'(MemtoRegW),    32'h1);
      chk("ld_RegWriteW", 32'(RegWriteW),    32'h1);
      chk("ld_WriteRegW", 32'(WriteRegW),    32'h7);

      // Store acked on the fourth cycle: three stalls and three bubbles
      drive_e(1'b0, 1'b1, 4'b0010, 5'd0, 32'h80, 32'h55, 32'h10C);
      tick();
      drive_e(1'b1, 1'b0, 4'b0010, 5'd9, 32'h99, 32'h0, 32'h110);
      settle();
      for (int i = 0; i < 3; i++) begin
         chk("st_StallM", 32'(StallM),   32'h1);
         chk("st_we",     32'(dmem_we),  32'h1);
         chk("st_addr",   dmem_addr,     32'h80);
         chk("st_wdata",  dmem_wdata,    32'h55);
         tick();
         settle();
         chk("st_bubble", 32'(RegWriteW), 32'h0);
         chk("st_holdM",  ALUOutM,        32'h80);
      end
      dmem_ack = 1'b1;
      #0;
      chk("st_ack_nostall", 32'(StallM), 32'h0);
      tick();
      dmem_ack = 1'b0;
      nop_e();
      settle();
      chk("st_next_M",     ALUOutM,          32'h99);
      chk("st_ALUOutW",    ALUOutW,          32'h80);
      chk("st_RegWriteW",  32'(RegWriteW),   32'h0);
      tick();
      settle();
      chk("st_next_W",     ALUOutW,          32'h99);
      chk("st_next_RW",    32'(RegWriteW),   32'h1);
      chk("st_next_WR",    32'(WriteRegW),   32'h9);

      // Load with no ack times out after 16 stall cycles
      drive_e(1'b1, 1'b0, 4'b0001, 5'd3, 32'h100, 32'h0, 32'h114);
      tick();
      drive_e(1'b1, 1'b0, 4'b0010, 5'd4, 32'h777, 32'h0, 32'h118);
      settle();
      stalls = 0;
      for (int i = 0; i < 40; i++) begin
         if (!StallM) break;
         stalls++;
         tick();
         settle();
      end
      chk("to_stalls",  32'(stalls),   32'd16);
      chk("to_err_pre", 32'(MemErr),   32'h0);
      tick();
      nop_e();
      settle();
      chk("to_MemErr",    32'(MemErr),     32'h1);
      chk("to_RegWriteW", 32'(RegWriteW),  32'h0);
      chk("to_ReadDataW", ReadDataW,       32'h0);
      chk("to_next_M",    ALUOutM,         32'h777);
      tick();
      settle();
      chk("to_next_W",    ALUOutW,         32'h777);
      chk("to_next_RW",   32'(RegWriteW),  32'h1);
      chk("to_next_WR",   32'(WriteRegW),  32'h4);
      chk("to_err_hold",  32'(MemErr),     32'h1);

      // Reset asserted mid-wait abandons the access
      drive_e(1'b1, 1'b0, 4'b0001, 5'd6, 32'h200, 32'h0, 32'h11C);
      tick();
      nop_e();
      settle();
      chk("rw_stall0", 32'(StallM), 32'h1);
      tick();
      settle();
      chk("rw_stall1", 32'(StallM), 32'h1);
      chk("rw_err",    32'(MemErr), 32'h1);
      rst = 1'b1;
      #1;
      chk("rw_StallM",    32'(StallM),    32'h0);
      chk("rw_req",       32'(dmem_req),  32'h0);
      chk("rw_MemtoRegM", 32'(MemtoRegM), 32'hE);
      chk("rw_MemtoRegW", 32'(MemtoRegW), 32'h2);
      chk("rw_RegWriteW", 32'(RegWriteW), 32'h0);
      chk("rw_ReadDataW", ReadDataW,      32'h0);
      chk("rw_ALUOutW",   ALUOutW,        32'h0);
      chk("rw_MemErr",    32'(MemErr),    32'h0);
      tick();
      settle();
      chk("rw_hold_RW",   32'(RegWriteW), 32'h0);
      chk("rw_hold_req",  32'(dmem_req),  32'h0);
      rst = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
